// File: rtl/ad9970_pkg.sv
// Shared constants, register map and configuration payload for the AD9970
// serial configuration front-end.
package ad9970_pkg;

  localparam int unsigned SER_ADDR_W     = 12;
  localparam int unsigned SER_DATA_W     = 16;
  localparam int unsigned SER_FRAME_W    = SER_ADDR_W + SER_DATA_W;
  localparam int unsigned LOC_W          = 13;
  localparam int unsigned SYNC_W         = 16;
  localparam int unsigned NUM_SYNC_WORDS = 7;

  localparam int unsigned ADDR_SYNC_CTRL   = 'h000;
  localparam int unsigned ADDR_SYNC_START  = 'h001;
  localparam int unsigned ADDR_SYNC_WORD0  = 'h002;
  localparam int unsigned ADDR_SYNC_WORD6  = 'h008;
  localparam int unsigned ADDR_HBLK_TOG1   = 'h009;
  localparam int unsigned ADDR_HBLK_TOG2   = 'h00A;
  localparam int unsigned ADDR_UPDATE_CTRL = 'h00B;

  typedef struct packed {
    logic                                  sync_align_loc;
    logic [LOC_W-1:0]                      sync_start_loc;
    logic [NUM_SYNC_WORDS-1:0][SYNC_W-1:0] sync_word;
    logic [LOC_W-1:0]                      hblk_tog1;
    logic [LOC_W-1:0]                      hblk_tog2;
  } cfg_t;

  localparam cfg_t CFG_RESET = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/ad_sync_edge.sv
// N-stage synchroniser for one asynchronous pin with registered level and
// rise/fall pulses taken from the last two stages (equal latency on all three).
module ad_sync_edge #(
  parameter int unsigned STAGES  = 3,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RST_VAL}};
      level  <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      level  <= sync_q[STAGES-2];
      rise   <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
      fall   <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end
  end

endmodule

// File: rtl/ad_serial_config.sv
// 3-wire serial write deserialiser and configuration register bank feeding the
// AD9970 timing generator, with immediate or VD-synchronous output update.
module ad_serial_config
  import ad9970_pkg::*;
#(
  parameter int unsigned ADDR_W      = SER_ADDR_W,
  parameter int unsigned DATA_W      = SER_DATA_W,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_sl,
  input  logic        i_sck,
  input  logic        i_sdata,
  input  logic        i_vd,
  output logic        o_sync_align_loc,
  output logic [12:0] ov_sync_start_loc,
  output logic [15:0] ov_sync_word0,
  output logic [15:0] ov_sync_word1,
  output logic [15:0] ov_sync_word2,
  output logic [15:0] ov_sync_word3,
  output logic [15:0] ov_sync_word4,
  output logic [15:0] ov_sync_word5,
  output logic [15:0] ov_sync_word6,
  output logic [12:0] ov_hblk_tog1,
  output logic [12:0] ov_hblk_tog2,
  output logic        o_update_mode,
  output logic        o_wr_done,
  output logic        o_frame_err,
  output logic        o_addr_err
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);

  logic sl_lvl, sl_rise, sl_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic sdata_lvl, sdata_rise, sdata_fall;
  logic vd_lvl, vd_rise, vd_fall;

  // SL idles high, so its chain resets high to avoid a phantom frame start.
  ad_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sl (
    .clk(clk), .reset_n(reset_n), .d(i_sl),
    .level(sl_lvl), .rise(sl_rise), .fall(sl_fall)
  );
  ad_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .d(i_sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  ad_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (
    .clk(clk), .reset_n(reset_n), .d(i_sdata),
    .level(sdata_lvl), .rise(sdata_rise), .fall(sdata_fall)
  );
  ad_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_vd (
    .clk(clk), .reset_n(reset_n), .d(i_vd),
    .level(vd_lvl), .rise(vd_rise), .fall(vd_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sl_rise, sl_fall, sck_lvl, sck_fall,
                          sdata_rise, sdata_fall, vd_lvl, vd_rise};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               first_q, first_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  cfg_t               pend_q, pend_d;
  cfg_t               out_q, out_d;
  logic               mode_q, mode_d;
  logic               commit_q, commit_d;
  logic               wr_done_q, wr_done_d;
  logic               frame_err_q, frame_err_d;
  logic               addr_err_q, addr_err_d;

  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [CNT_W-1:0]   pos;
  logic [CNT_W-1:0]   last;
  logic               mapped;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      first_q     <= 1'b0;
      addr_q      <= '0;
      pend_q      <= CFG_RESET;
      out_q       <= CFG_RESET;
      mode_q      <= 1'b0;
      commit_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      first_q     <= first_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      mode_q      <= mode_d;
      commit_q    <= commit_d;
      wr_done_q   <= wr_done_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    first_d     = first_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    mode_d      = mode_q;
    commit_d    = 1'b0;
    wr_done_d   = 1'b0;
    frame_err_d = 1'b0;
    addr_err_d  = 1'b0;
    mapped      = 1'b0;
    // First word of a frame carries its own address; later words use auto-increment.
    wr_addr = first_q ? shreg_q[ADDR_W-1:0] : addr_q;
    wr_data = shreg_q[FRAME_W-1:ADDR_W];
    pos     = first_q ? bit_cnt_q : bit_cnt_q + CNT_W'(ADDR_W);
    last    = first_q ? CNT_W'(FRAME_W - 1) : CNT_W'(DATA_W - 1);

    unique case (state_q)
      ST_IDLE: begin
        if (!sl_lvl) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          shreg_d   = '0;
          first_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sl_lvl) begin
          state_d     = ST_IDLE;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
        end else if (sck_rise) begin
          shreg_d[pos] = sdata_lvl;
          bit_cnt_d    = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == last) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mapped = 1'b1;
        if (wr_addr == ADDR_W'(ADDR_SYNC_CTRL))
          pend_d.sync_align_loc = wr_data[0];
        else if (wr_addr == ADDR_W'(ADDR_SYNC_START))
          pend_d.sync_start_loc = LOC_W'(wr_data);
        else if (wr_addr >= ADDR_W'(ADDR_SYNC_WORD0) && wr_addr <= ADDR_W'(ADDR_SYNC_WORD6))
          pend_d.sync_word[3'(wr_addr - ADDR_W'(ADDR_SYNC_WORD0))] = SYNC_W'(wr_data);
        else if (wr_addr == ADDR_W'(ADDR_HBLK_TOG1))
          pend_d.hblk_tog1 = LOC_W'(wr_data);
        else if (wr_addr == ADDR_W'(ADDR_HBLK_TOG2))
          pend_d.hblk_tog2 = LOC_W'(wr_data);
        else if (wr_addr == ADDR_W'(ADDR_UPDATE_CTRL))
          mode_d = wr_data[0];
        else
          mapped = 1'b0;
        wr_done_d  = mapped;
        addr_err_d = ~mapped;
        commit_d   = mapped & ~mode_d;
        bit_cnt_d  = '0;
        shreg_d    = '0;
        first_d    = 1'b0;
        addr_d     = wr_addr + ADDR_W'(1);
        state_d    = sl_lvl ? ST_IDLE : ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase

    // A VD commit takes pend_d so a write in the same cycle is not lost.
    out_d = out_q;
    if (commit_q) out_d = pend_q;
    if (vd_fall && mode_q) out_d = pend_d;
  end

  assign o_sync_align_loc  = out_q.sync_align_loc;
  assign ov_sync_start_loc = out_q.sync_start_loc;
  assign ov_sync_word0     = out_q.sync_word[0];
  assign ov_sync_word1     = out_q.sync_word[1];
  assign ov_sync_word2     = out_q.sync_word[2];
  assign ov_sync_word3     = out_q.sync_word[3];
  assign ov_sync_word4     = out_q.sync_word[4];
  assign ov_sync_word5     = out_q.sync_word[5];
  assign ov_sync_word6     = out_q.sync_word[6];
  assign ov_hblk_tog1      = out_q.hblk_tog1;
  assign ov_hblk_tog2      = out_q.hblk_tog2;
  assign o_update_mode     = mode_q;
  assign o_wr_done         = wr_done_q;
  assign o_frame_err       = frame_err_q;
  assign o_addr_err        = addr_err_q;

endmodule

// File: tb/tb_ad_serial_config.sv
// Directed bench for ad_serial_config: serial frames, bursts, VD commit,
// framing/address errors and mid-frame reset.
module tb_ad_serial_config;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_sl = 1'b1;
  logic        i_sck = 1'b0;
  logic        i_sdata = 1'b0;
  logic        i_vd = 1'b0;
  logic        o_sync_align_loc;
  logic [12:0] ov_sync_start_loc;
  logic [15:0] ov_sync_word0, ov_sync_word1, ov_sync_word2, ov_sync_word3;
  logic [15:0] ov_sync_word4, ov_sync_word5, ov_sync_word6;
  logic [12:0] ov_hblk_tog1, ov_hblk_tog2;
  logic        o_update_mode, o_wr_done, o_frame_err, o_addr_err;

  ad_serial_config dut (
    .clk(clk), .reset_n(reset_n),
    .i_sl(i_sl), .i_sck(i_sck), .i_sdata(i_sdata), .i_vd(i_vd),
    .o_sync_align_loc(o_sync_align_loc), .ov_sync_start_loc(ov_sync_start_loc),
    .ov_sync_word0(ov_sync_word0), .ov_sync_word1(ov_sync_word1),
    .ov_sync_word2(ov_sync_word2), .ov_sync_word3(ov_sync_word3),
    .ov_sync_word4(ov_sync_word4), .ov_sync_word5(ov_sync_word5),
    .ov_sync_word6(ov_sync_word6),
    .ov_hblk_tog1(ov_hblk_tog1), .ov_hblk_tog2(ov_hblk_tog2),
    .o_update_mode(o_update_mode), .o_wr_done(o_wr_done),
    .o_frame_err(o_frame_err), .o_addr_err(o_addr_err)
  );

  always #5 clk = ~clk;

  logic [152:0] all_out;
  assign all_out = {o_sync_align_loc, ov_sync_start_loc,
                    ov_sync_word6, ov_sync_word5, ov_sync_word4, ov_sync_word3,
                    ov_sync_word2, ov_sync_word1, ov_sync_word0,
                    ov_hblk_tog1, ov_hblk_tog2, o_update_mode};

  int  total = 0;
  int  bad = 0;
  int  n_wr = 0, n_ferr = 0, n_aerr = 0;
  time wr_t = 0, w0_t = 0, t2_t = 0, last_rise_t = 0;
  logic [15:0] w0_prev = '0;
  logic [12:0] t2_prev = '0;

  // Pulse counters and output-change timestamps, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_wr_done) begin n_wr++; wr_t = $time; end
    if (o_frame_err) n_ferr++;
    if (o_addr_err) n_aerr++;
    if (ov_sync_word0 !== w0_prev) begin w0_t = $time; w0_prev = ov_sync_word0; end
    if (ov_hblk_tog2 !== t2_prev) begin t2_t = $time; t2_prev = ov_hblk_tog2; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sl_begin();
    tick(1);
    i_sl = 1'b0;
    tick(8);
  endtask

  task automatic sl_end();
    i_sck = 1'b0;
    tick(4);
    i_sl = 1'b1;
    tick(10);
  endtask

  // LSB first; SCK period is 8 clk. vd_hit drops VD one clk after the last rise.
  task automatic send_bits(input logic [27:0] v, input int n, input bit vd_hit = 1'b0);
    for (int i = 0; i < n; i++) begin
      i_sdata = v[i];
      i_sck   = 1'b0;
      tick(4);
      i_sck       = 1'b1;
      last_rise_t = $time;
      if (vd_hit && i == n - 1) begin
        tick(1);
        i_vd = 1'b0;
        tick(3);
      end else begin
        tick(4);
      end
    end
  endtask

  task automatic write_frame(input logic [11:0] addr, input logic [15:0] data);
    sl_begin();
    send_bits({data, addr}, 28);
    sl_end();
  endtask

  task automatic test_reset();
    tick(3);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_outputs_in_reset got=%h exp=0", all_out); end
    reset_n = 1'b1;
    tick(6);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_outputs_after got=%h exp=0", all_out); end
    total++;
    if ({o_wr_done, o_frame_err, o_addr_err} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses got=%b exp=000", {o_wr_done, o_frame_err, o_addr_err});
    end
  endtask

  task automatic test_single();
    int wr0, err0;
    wr0  = n_wr;
    err0 = n_ferr + n_aerr;
    write_frame(12'h002, 16'hA5C3);
    total++;
    if (n_wr - wr0 !== 1) begin bad++; $display("FAIL single_wr_done_count got=%0d exp=1", n_wr - wr0); end
    total++;
    if (wr_t - last_rise_t !== 64'd50) begin
      bad++; $display("FAIL single_wr_done_latency got=%0d exp=50", wr_t - last_rise_t);
    end
    total++;
    if (w0_t - wr_t !== 64'd10) begin bad++; $display("FAIL single_out_latency got=%0d exp=10", w0_t - wr_t); end
    total++;
    if (all_out !== {1'b0, 13'd0, 96'd0, 16'hA5C3, 26'd0, 1'b0}) begin
      bad++; $display("FAIL single_outputs got=%h exp=word0 a5c3 only", all_out);
    end
    total++;
    if (n_ferr + n_aerr - err0 !== 0) begin bad++; $display("FAIL single_errors got=%0d exp=0", n_ferr + n_aerr - err0); end
  endtask

  task automatic test_burst();
    int wr0, err0;
    wr0  = n_wr;
    err0 = n_ferr + n_aerr;
    sl_begin();
    send_bits({16'h1111, 12'h002}, 28);
    for (int k = 2; k <= 7; k++) send_bits(28'(k * 16'h1111), 16);
    sl_end();
    total++;
    if (n_wr - wr0 !== 7) begin bad++; $display("FAIL burst_wr_done_count got=%0d exp=7", n_wr - wr0); end
    total++;
    if (all_out !== {1'b0, 13'd0, 16'h7777, 16'h6666, 16'h5555, 16'h4444,
                     16'h3333, 16'h2222, 16'h1111, 26'd0, 1'b0}) begin
      bad++; $display("FAIL burst_outputs got=%h exp=words 7777..1111", all_out);
    end
    total++;
    if (n_ferr + n_aerr - err0 !== 0) begin bad++; $display("FAIL burst_errors got=%0d exp=0", n_ferr + n_aerr - err0); end
  endtask

  task automatic test_vd();
    i_vd = 1'b1;
    tick(10);
    write_frame(12'h00B, 16'h0001);
    total++;
    if (o_update_mode !== 1'b1) begin bad++; $display("FAIL vd_mode_set got=%b exp=1", o_update_mode); end
    write_frame(12'h009, 16'h0100);
    tick(10);
    total++;
    if (ov_hblk_tog1 !== 13'h0000) begin bad++; $display("FAIL vd_held got=%h exp=0000", ov_hblk_tog1); end
    i_vd = 1'b0;
    tick(8);
    total++;
    if (ov_hblk_tog1 !== 13'h0100) begin bad++; $display("FAIL vd_commit got=%h exp=0100", ov_hblk_tog1); end
    i_vd = 1'b1;
    tick(8);
    sl_begin();
    send_bits({16'h0ABC, 12'h00A}, 28, 1'b1);
    sl_end();
    total++;
    if (ov_hblk_tog2 !== 13'h0ABC) begin bad++; $display("FAIL vd_bypass_value got=%h exp=0abc", ov_hblk_tog2); end
    total++;
    if (t2_t !== wr_t) begin bad++; $display("FAIL vd_bypass_time got=%0d exp=%0d", t2_t, wr_t); end
    i_vd = 1'b1;
    tick(8);
    write_frame(12'h00B, 16'h0000);
    total++;
    if (o_update_mode !== 1'b0) begin bad++; $display("FAIL vd_mode_clear got=%b exp=0", o_update_mode); end
  endtask

  task automatic test_frame_err();
    logic [152:0] snap;
    int wr0, fe0;
    snap = all_out;
    wr0  = n_wr;
    fe0  = n_ferr;
    sl_begin();
    send_bits({16'hFFFF, 12'h003}, 15);
    sl_end();
    total++;
    if (n_ferr - fe0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - fe0); end
    total++;
    if (n_wr - wr0 !== 0) begin bad++; $display("FAIL ferr_no_write got=%0d exp=0", n_wr - wr0); end
    total++;
    if (all_out !== snap) begin bad++; $display("FAIL ferr_outputs got=%h exp=%h", all_out, snap); end
    write_frame(12'h003, 16'h0BAD);
    total++;
    if (ov_sync_word1 !== 16'h0BAD) begin bad++; $display("FAIL ferr_recover got=%h exp=0bad", ov_sync_word1); end
    total++;
    if (n_ferr - fe0 !== 1) begin bad++; $display("FAIL ferr_recover_count got=%0d exp=1", n_ferr - fe0); end
  endtask

  task automatic test_addr_err();
    logic [152:0] snap;
    int wr0, ae0;
    snap = all_out;
    wr0  = n_wr;
    ae0  = n_aerr;
    write_frame(12'h0FF, 16'h1234);
    total++;
    if (n_aerr - ae0 !== 1) begin bad++; $display("FAIL aerr_count got=%0d exp=1", n_aerr - ae0); end
    total++;
    if (n_wr - wr0 !== 0) begin bad++; $display("FAIL aerr_no_write got=%0d exp=0", n_wr - wr0); end
    total++;
    if (all_out !== snap) begin bad++; $display("FAIL aerr_outputs got=%h exp=%h", all_out, snap); end
    sl_begin();
    send_bits({16'h5555, 12'hFFF}, 28);
    send_bits(28'h0000001, 16);
    sl_end();
    total++;
    if (n_aerr - ae0 !== 2 || n_wr - wr0 !== 1) begin
      bad++; $display("FAIL wrap_counts got aerr=%0d wr=%0d exp aerr=2 wr=1", n_aerr - ae0, n_wr - wr0);
    end
    total++;
    if (o_sync_align_loc !== 1'b1) begin bad++; $display("FAIL wrap_align got=%b exp=1", o_sync_align_loc); end
  endtask

  task automatic test_midframe_reset();
    int wr0;
    sl_begin();
    send_bits({16'hFFFF, 12'h001}, 10);
    reset_n = 1'b0;
    #1;
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL rst_async_clear got=%h exp=0", all_out); end
    i_sck = 1'b0;
    i_sl  = 1'b1;
    tick(4);
    reset_n = 1'b1;
    tick(6);
    wr0 = n_wr;
    write_frame(12'h001, 16'hFFFF);
    total++;
    if (n_wr - wr0 !== 1) begin bad++; $display("FAIL rst_fresh_count got=%0d exp=1", n_wr - wr0); end
    total++;
    if (all_out !== {1'b0, 13'h1FFF, 112'd0, 26'd0, 1'b0}) begin
      bad++; $display("FAIL rst_fresh_outputs got=%h exp=start_loc 1fff only", all_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_vd();
    test_frame_err();
    test_addr_err();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
